// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchroniser followed by a stability counter.
// A level change on the synchronised input must hold for STABLE_CYCLES
// consecutive cycles before dout follows it. Any bounce back to the old
// level discards the count, so dout is clean enough to feed an edge detector.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   rst      - synchronous active-low reset
//   din      - raw asynchronous level
//   dout     - debounced, synchronised level (registered)
//   settling - high while a candidate change is being qualified (registered)
module debounce_sync #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic settling
);

  // Terminal count: reaching it with s2 still different commits the change.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_dout;
  logic             r_settling;
  logic [CNT_W-1:0] r_cnt;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_dout_nxt;
  logic             w_settling_nxt;

  // Next-state: the counter itself encodes STABLE (0) versus SETTLING (!=0).
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_dout_nxt     = r_dout;
    w_settling_nxt = 1'b0;
    if (r_s2 == r_dout) begin
      // Input agrees with output: nothing pending, drop any partial count.
      w_cnt_nxt = '0;
    end else if (r_cnt == CNT_LAST) begin
      w_dout_nxt = r_s2;
      w_cnt_nxt  = '0;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
    // Registered copy of (cnt != 0), so it can never be high on a dout change.
    w_settling_nxt = (w_cnt_nxt != '0);
  end

  // State registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_dout     <= 1'b0;
      r_cnt      <= '0;
      r_settling <= 1'b0;
    end else begin
      r_s1       <= din;
      r_s2       <= r_s1;
      r_dout     <= w_dout_nxt;
      r_cnt      <= w_cnt_nxt;
      r_settling <= w_settling_nxt;
    end
  end

  assign dout     = r_dout;
  assign settling = r_settling;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: a default instance (STABLE_CYCLES = 4) and a
// STABLE_CYCLES = 1 instance. Stimulus pushes hand-derived per-cycle
// expectations into a queue; a monitor pops them and compares.
module tb_debounce_sync;

  logic clk;
  logic rst;
  logic din0;
  logic din1;
  logic dout0;
  logic settling0;
  logic dout1;
  logic settling1;

  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;
  logic prev_dout0 = 1'b0;

  typedef struct {
    int         cyc;
    bit         unit;
    logic       dout;
    logic       settling;
    bit [63:0]  tag;
  } exp_t;

  exp_t q[$];

  debounce_sync #(.STABLE_CYCLES(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .din      (din0),
    .dout     (dout0),
    .settling (settling0)
  );

  debounce_sync #(.STABLE_CYCLES(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .din      (din1),
    .dout     (dout1),
    .settling (settling1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (dout0 !== prev_dout0) begin
      n_total++;
      if (settling0 !== 1'b0) begin
        $display("FAIL settling_on_change cyc=%0d settling=%b required=0", cyc, settling0);
      end else begin
        n_pass++;
      end
    end
    prev_dout0 = dout0;
    n_total++;
    if (settling1 !== 1'b0) begin
      $display("FAIL sc1_settling cyc=%0d settling=%b required=0", cyc, settling1);
    end else begin
      n_pass++;
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_total++;
      $display("FAIL %0s missed expectation for cyc=%0d (now %0d)", q[0].tag, q[0].cyc, cyc);
      void'(q.pop_front());
    end
    while (q.size() > 0 && q[0].cyc == cyc) begin
      logic ad;
      logic as;
      exp_t e;
      e = q.pop_front();
      ad = e.unit ? dout1 : dout0;
      as = e.unit ? settling1 : settling0;
      n_total++;
      if (ad !== e.dout || as !== e.settling) begin
        $display("FAIL %0s unit=%0d cyc=%0d dout=%b settling=%b required dout=%b settling=%b",
                 e.tag, e.unit, cyc, ad, as, e.dout, e.settling);
      end else begin
        n_pass++;
      end
    end
  end

  task automatic push(input int k, input bit u, input logic d, input logic s, input bit [63:0] t);
    exp_t e;
    e.cyc = k;
    e.unit = u;
    e.dout = d;
    e.settling = s;
    e.tag = t;
    q.push_back(e);
  endtask

  // Clean qualification on the SC=4 unit, din changed at the negedge after edge c.
  task automatic qual(input int c, input logic ov, input logic nv, input bit [63:0] t);
    push(c + 2, 1'b0, ov, 1'b0, t);
    for (int i = 3; i <= 5; i++) push(c + i, 1'b0, ov, 1'b1, t);
    push(c + 6, 1'b0, nv, 1'b0, t);
  endtask

  task automatic hold(input int from, input int upto, input logic v, input bit [63:0] t);
    for (int k = from; k <= upto; k++) push(k, 1'b0, v, 1'b0, t);
  endtask

  // Table of n expectations for edges c+1..c+n, leftmost bit first.
  task automatic push_tab(input int c, input bit [63:0] t, input logic [15:0] dv,
                          input logic [15:0] sv, input int n);
    for (int i = 0; i < n; i++) push(c + 1 + i, 1'b0, dv[n-1-i], sv[n-1-i], t);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    logic [7:0] seq;
    rst  = 1'b0;
    din0 = 1'b1;
    din1 = 1'b0;

    // 1: reset held for edges 1-2 with din high; capture at edge 3, rise at 8.
    for (int k = 1; k <= 3; k++) push(k, 1'b0, 1'b0, 1'b0, "reset");
    qual(2, 1'b0, 1'b1, "rst_rise");
    hold(9, 10, 1'b1, "rst_hold");
    tick;
    tick;
    rst = 1'b1;
    repeat (8) tick;

    // 2: clean fall, rise, fall.
    tick;
    c = cyc; din0 = 1'b0; qual(c, 1'b1, 1'b0, "fall_a"); hold(c + 7, c + 10, 1'b0, "low_a");
    repeat (10) tick;
    c = cyc; din0 = 1'b1; qual(c, 1'b0, 1'b1, "rise_b"); hold(c + 7, c + 10, 1'b1, "high_b");
    repeat (10) tick;
    c = cyc; din0 = 1'b0; qual(c, 1'b1, 1'b0, "fall_b"); hold(c + 7, c + 10, 1'b0, "low_b");
    repeat (10) tick;

    // 3: bounce 1,1,0,1,1,1,0 then steady high.
    c = cyc;
    push_tab(c, "bounce", 16'b0000000000001, 16'b0011011101110, 13);
    hold(c + 14, c + 16, 1'b1, "bnc_hold");
    seq = 8'b11011101;
    for (int i = 0; i < 8; i++) begin
      din0 = seq[7-i];
      tick;
    end
    repeat (8) tick;

    // 4: return low, then a 3-cycle and a 4-cycle pulse.
    c = cyc; din0 = 1'b0; qual(c, 1'b1, 1'b0, "fall_c"); hold(c + 7, c + 10, 1'b0, "low_c");
    repeat (10) tick;
    c = cyc;
    push_tab(c, "pulse3", 16'b0000000, 16'b0011100, 7);
    din0 = 1'b1;
    repeat (3) tick;
    din0 = 1'b0;
    repeat (8) tick;
    c = cyc;
    push_tab(c, "pulse4", 16'b00000111100, 16'b00111011100, 11);
    din0 = 1'b1;
    repeat (4) tick;
    din0 = 1'b0;
    repeat (12) tick;

    // 5: reset at cnt=2 during a rise, then reset while dout is high.
    c = cyc;
    push_tab(c, "rst_mid", 16'b00000000001, 16'b00110001110, 11);
    hold(c + 12, c + 13, 1'b1, "mid_hold");
    din0 = 1'b1;
    repeat (4) tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    repeat (8) tick;
    c = cyc;
    push_tab(c, "rst_hi", 16'b0000001, 16'b0001110, 7);
    hold(c + 8, c + 9, 1'b1, "hi_hold");
    rst = 1'b0;
    tick;
    rst = 1'b1;
    repeat (8) tick;

    // 6: STABLE_CYCLES=1 unit, one-cycle pulse then a steady rise.
    c = cyc;
    push(c + 1, 1'b1, 1'b0, 1'b0, "sc1_pls");
    push(c + 2, 1'b1, 1'b0, 1'b0, "sc1_pls");
    push(c + 3, 1'b1, 1'b1, 1'b0, "sc1_pls");
    push(c + 4, 1'b1, 1'b0, 1'b0, "sc1_pls");
    push(c + 5, 1'b1, 1'b0, 1'b0, "sc1_pls");
    din1 = 1'b1;
    tick;
    din1 = 1'b0;
    repeat (6) tick;
    c = cyc;
    push(c + 2, 1'b1, 1'b0, 1'b0, "sc1_rise");
    push(c + 3, 1'b1, 1'b1, 1'b0, "sc1_rise");
    push(c + 4, 1'b1, 1'b1, 1'b0, "sc1_rise");
    din1 = 1'b1;
    repeat (6) tick;

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && q.size() > 0; i++) tick;
    n_total++;
    if (q.size() != 0) begin
      $display("FAIL drain pending=%0d required=0", q.size());
    end else begin
      n_pass++;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input conditioning stage that sits directly upstream of the rising-edge detector. It takes a raw, asynchronous, possibly bouncing level (push-button, external strobe), synchronises it into the `clk` domain with a two-flop synchroniser, and qualifies each level change with a stability counter. The result is a clean, glitch-free level, `dout`, that drives the edge detector's `D` input directly.

## Interface
- `STABLE_CYCLES`, default 4: consecutive cycles the synchronised input must hold a new value before `dout` follows it; legal range 1 to 65535.
- `CNT_W`, default `$clog2(STABLE_CYCLES+1)`: counter width; derived, never overridden.

- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `din`  input  1  raw asynchronous level; no timing relationship to `clk`.
- `dout`  output  1  debounced, synchronised level; registered.
- `settling`  output  1  high while a candidate change is being qualified (`cnt != 0`); registered.

## Operation
- Synchroniser: `s1 <= din`, `s2 <= s1` on every edge. Only `s2` is used downstream; `din` and `s1` feed no other logic.
- Two states, encoded by the counter:
  - STABLE: `cnt == 0`.
  - SETTLING: `cnt != 0`.
- Per-edge rules, outside reset:
  - `s2 == dout`: `cnt <= 0`. A bounce back to the old level abandons the candidate.
  - `s2 != dout` and `cnt == STABLE_CYCLES-1`: `dout <= s2` and `cnt <= 0`.
  - `s2 != dout` otherwise: `cnt <= cnt + 1`.
- `settling` equals `cnt != 0`, taken from the registered counter. It is never high in the same cycle that `dout` changes.
- `STABLE_CYCLES = 1`: `dout` follows `s2` with one register delay. `settling` stays low permanently.
- Rising and falling transitions are qualified identically.
- The counter never exceeds `STABLE_CYCLES-1`, so it cannot wrap.

## Timing
- Reset: on any rising edge with `rst == 0`, `s1`, `s2`, `dout` and `cnt` all clear to 0, so `settling` is also 0. Reset overrides every other rule.
- Reset asserted mid-settling abandons the count. `dout` returns to 0 even if it was 1.
- The first qualification after reset release starts from `cnt = 0`.
- Latency: suppose `din` is stable at the new value from before edge N, where N is the edge that first captures it into `s1`. Then:
  - `s2` changes at edge N+1.
  - `cnt` counts at edges N+2 through N+STABLE_CYCLES.
  - `dout` changes at edge N+1+STABLE_CYCLES.
  - With the default of 4, `dout` changes 5 edges after capture.
- Glitch rejection: a pulse on `s2` shorter than `STABLE_CYCLES` cycles never reaches `dout`. The counter returns to 0 on the first edge at which `s2 == dout` again.
- Restart: a pulse that returns and then departs again restarts counting from 0. There is no partial credit across bounces.
- Throughput: `dout` changes at most once every `STABLE_CYCLES` cycles once `s2` is steady.
- Downstream view: the edge detector sees at most one rising edge of `dout` per qualified low-to-high transition of `din`.

## Test plan
Common setup: 10 ns clock, `STABLE_CYCLES = 4`. For every scenario, check `settling == (cnt != 0)` and `dout` reset value 0 every cycle.

1. Reset: hold `rst = 0` for 2 edges while `din = 1`, then release. Required: `dout = 0` and `settling = 0` throughout reset. `dout` rises exactly 5 edges after the first post-release edge that captures `din = 1`.
2. Clean rise and fall: drive `din` 0→1, hold 10 cycles, then 1→0. Required: `dout` rises 5 edges after capture, with `settling` high for the 3 preceding cycles. `dout` falls 5 edges after the falling capture.
3. Bounce: drive `din` high for 2 cycles, low for 1, high for 3, low for 1, then high steadily. Required: `dout` stays 0 through all bounces and rises only 5 edges after the final steady capture. `settling` returns to 0 after each bounce.
4. Marginal pulse: a 3-cycle `din` high pulse never sets `dout`. A 4-cycle pulse sets `dout` for at least 4 cycles.
5. Reset mid-settling: pull `rst` low when `cnt = 2` after a rise. Required: `cnt`, `settling` and `dout` are 0 at that edge. After release, a fresh 5-edge qualification is needed.
6. `STABLE_CYCLES = 1` instance: a 1-cycle `s2` pulse passes to `dout` one edge later. `settling` never asserts.
